// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART transmit framer: frame
//               state encoding, data width and idle line level.
//               Build macro UART_TX_PARITY_EN adds the PARITY state.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic LINE_IDLE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START_BIT = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP_BIT  = 3'd3
`ifdef UART_TX_PARITY_EN
        ,
        ST_PARITY    = 3'd4
`endif
    } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_baud_ctr.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_ctr
// Description : Bit-period timer. Counts 0..CLK_PER_BIT-1 and pulses
//               bit_done on the last cycle of each bit period, restarting
//               from 0 on every bit boundary so no drift accumulates.
// Ports       : clk      - clock (rising edge)
//               rst      - synchronous active-high reset
//               clear    - hold counter at 0
//               bit_done - high during the last cycle of a bit period
// Parameters  : CLK_PER_BIT - clock cycles per serial bit (2..65535)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_ctr #(
    parameter int CLK_PER_BIT = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_done
);

    localparam int CTR_SIZE = $clog2(CLK_PER_BIT);
    localparam logic [CTR_SIZE-1:0] c_CTR_LAST = CTR_SIZE'(CLK_PER_BIT - 1);
    localparam logic [CTR_SIZE-1:0] c_CTR_ONE  = CTR_SIZE'(1);

    logic [CTR_SIZE-1:0] r_ctr;

    assign bit_done = (r_ctr == c_CTR_LAST);

    always_ff @(posedge clk) begin
        if (rst || clear || bit_done) begin
            r_ctr <= '0;
        end else begin
            r_ctr <= r_ctr + c_CTR_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_framer
// Description : UART transmit framer, 8N1 by default. Accepts one byte per
//               new_data strobe when idle and not flow-blocked, then sends
//               start bit, 8 data bits LSB first and a stop bit.
//               Define UART_TX_PARITY_EN to insert an even parity bit
//               between the data and stop bits (8E1).
// Ports       : clk      - clock (rising edge)
//               rst      - synchronous active-high reset
//               tx       - serial line output, idle high (registered)
//               block    - downstream hold; inhibits new frames
//               busy     - high when a byte cannot be accepted (registered)
//               data     - byte to transmit, sampled on acceptance
//               new_data - single-cycle strobe offering data
// Parameters  : CLK_PER_BIT - clock cycles per serial bit (2..65535)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 50
) (
    input  logic       clk,
    input  logic       rst,
    output logic       tx,
    input  logic       block,
    output logic       busy,
    input  logic [7:0] data,
    input  logic       new_data
);

    localparam logic [2:0] c_LAST_BIT = 3'(DATA_BITS - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_data;
    logic [2:0] r_bit_idx;
    logic [2:0] w_bit_idx_next;
    logic       r_block_q;
    logic       w_accept;
    logic       w_bit_done;
    logic       w_tx_next;
    logic       w_clear;

    assign w_accept = (r_state == ST_IDLE) && !r_block_q && new_data;

    // Counter is parked at 0 whenever idle, so every frame starts with a
    // full-length start bit regardless of when the byte arrives.
    assign w_clear = (r_state == ST_IDLE);

    uart_baud_ctr #(
        .CLK_PER_BIT (CLK_PER_BIT)
    ) u_baud_ctr (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_clear),
        .bit_done (w_bit_done)
    );

    always_comb begin
        w_state_next   = r_state;
        w_bit_idx_next = r_bit_idx;
        case (r_state)
            ST_IDLE: begin
                w_bit_idx_next = 3'd0;
                if (w_accept) begin
                    w_state_next = ST_START_BIT;
                end
            end
            ST_START_BIT: begin
                if (w_bit_done) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_done) begin
                    // Index wraps 7->0 on the final data bit.
                    w_bit_idx_next = r_bit_idx + 3'd1;
                    if (r_bit_idx == c_LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = ST_PARITY;
`else
                        w_state_next = ST_STOP_BIT;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_bit_done) begin
                    w_state_next = ST_STOP_BIT;
                end
            end
`endif
            ST_STOP_BIT: begin
                if (w_bit_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // tx is registered from the level belonging to the next state, so the
    // line changes in the same cycle the state does.
    always_comb begin
        w_tx_next = LINE_IDLE;
        case (w_state_next)
            ST_START_BIT: w_tx_next = 1'b0;
            ST_DATA:      w_tx_next = r_data[w_bit_idx_next];
`ifdef UART_TX_PARITY_EN
            ST_PARITY:    w_tx_next = ^r_data;
`endif
            default:      w_tx_next = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_bit_idx <= 3'd0;
            r_block_q <= 1'b0;
            r_data    <= 8'h00;
            tx        <= LINE_IDLE;
            busy      <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_bit_idx <= w_bit_idx_next;
            r_block_q <= block;
            tx        <= w_tx_next;
            // busy tracks the registered block level, so it is high exactly
            // when the framer is mid-frame or block_q is set.
            busy      <= (w_state_next != ST_IDLE) || block;
            if (w_accept) begin
                r_data <= data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_framer
// Description : Self-checking bench for uart_tx_framer with CLK_PER_BIT=4.
//               Expected line levels come from a frame-level model of the
//               UART bit sequence. UART_TX_PARITY_EN selects 8E1 framing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_framer;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FLEN = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx;
    logic       block;
    logic       busy;
    logic [7:0] data;
    logic       new_data;

    int checks = 0;
    int errors = 0;

    uart_tx_framer #(
        .CLK_PER_BIT (CPB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx       (tx),
        .block    (block),
        .busy     (busy),
        .data     (data),
        .new_data (new_data)
    );

    always #5 clk = ~clk;

    // Line level during bit period 'period' of a frame carrying byte b.
    function automatic logic line_bit(input logic [7:0] b, input int period);
        int ones;
        if (period == 0) return 1'b0;
        if (period <= 8) return logic'((b >> (period - 1)) & 8'd1);
        if (period == NBITS - 1) return 1'b1;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'((b >> i) & 8'd1);
        return logic'(ones % 2);
    endfunction

    // Offers b at the current (idle) negedge and checks the whole frame.
    // junk_at >= 0 re-strobes new_data with junk mid-frame; blk_at >= 0
    // raises block mid-frame and leaves it high.
    task automatic send_frame(input logic [7:0] b, input int junk_at,
                              input int blk_at, input logic [7:0] junk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ready byte=%02h busy=%b expected=0", b, busy);
        end
        data     = b;
        new_data = 1'b1;
        for (int k = 0; k < FLEN; k++) begin
            @(negedge clk);
            new_data = 1'b0;
            checks++;
            if (tx !== line_bit(b, k / CPB)) begin
                errors++;
                $display("FAIL frame_tx byte=%02h cyc=%0d tx=%b expected=%b",
                         b, k, tx, line_bit(b, k / CPB));
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL frame_busy byte=%02h cyc=%0d busy=%b expected=1", b, k, busy);
            end
            if (k == junk_at) begin
                data     = junk;
                new_data = 1'b1;
            end
            if (k == blk_at) block = 1'b1;
        end
        @(negedge clk);
        new_data = 1'b0;
        checks++;
        if (busy !== block) begin
            errors++;
            $display("FAIL end_busy byte=%02h busy=%b expected=%b", b, busy, block);
        end
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL end_tx byte=%02h tx=%b expected=1", b, tx);
        end
    endtask

    task automatic check_idle(input int n, input logic exp_busy);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if (tx !== 1'b1) begin
                errors++;
                $display("FAIL idle_tx cyc=%0d tx=%b expected=1", i, tx);
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL idle_busy cyc=%0d busy=%b expected=%b", i, busy, exp_busy);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx tx=%b expected=1", tx);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy busy=%b expected=0", busy);
        end
        rst = 1'b0;
        check_idle(2, 1'b0);
    endtask

    task automatic test_single;
        send_frame(8'h68, -1, -1, 8'h00);
    endtask

    task automatic test_back_to_back;
        send_frame(8'h00, -1, -1, 8'h00);
        send_frame(8'hFF, -1, -1, 8'h00);
    endtask

    task automatic test_ignore_busy;
        send_frame(8'h41, 9, -1, 8'hFF);
        check_idle(4, 1'b0);
    endtask

    task automatic test_block;
        block = 1'b1;
        @(negedge clk);
        data     = 8'h55;
        new_data = 1'b1;
        check_idle(8, 1'b1);
        new_data = 1'b0;
        block    = 1'b0;
        check_idle(1, 1'b0);
        send_frame(8'h55, -1, -1, 8'h00);
    endtask

    task automatic test_reset_mid;
        data     = 8'hA5;
        new_data = 1'b1;
        // Cycle 16 is the first cycle of data bit 3.
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            new_data = 1'b0;
            checks++;
            if (tx !== line_bit(8'hA5, k / CPB)) begin
                errors++;
                $display("FAIL pre_rst_tx cyc=%0d tx=%b expected=%b", k, tx, line_bit(8'hA5, k / CPB));
            end
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_tx tx=%b expected=1", tx);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_busy busy=%b expected=0", busy);
        end
        rst = 1'b0;
        check_idle(1, 1'b0);
        send_frame(8'h12, -1, -1, 8'h00);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        send_frame(8'h07, -1, -1, 8'h00);
        send_frame(8'h03, -1, -1, 8'h00);
    endtask
`endif

    task automatic test_random;
        logic [7:0] b;
        int         junk_at;
        int         blk_at;
        for (int n = 0; n < 16; n++) begin
            check_idle($urandom_range(0, 3), 1'b0);
            b       = 8'($urandom);
            junk_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, FLEN - 1)) : -1;
            blk_at  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, FLEN - 1)) : -1;
            send_frame(b, junk_at, blk_at, 8'($urandom));
            if (blk_at >= 0) begin
                check_idle(2, 1'b1);
                block = 1'b0;
                check_idle(1, 1'b0);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        block    = 1'b0;
        new_data = 1'b0;
        data     = 8'h00;
        test_reset;
        test_single;
        test_back_to_back;
        test_ignore_busy;
        test_block;
        test_reset_mid;
`ifdef UART_TX_PARITY_EN
        test_parity;
`endif
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 Parameter CLK_PER_BIT, default 50, SHALL set the clock cycles per serial bit (50 MHz clock, 1 Mbaud); legal range 2..65535.
REQ-002 Derived localparam CTR_SIZE SHALL equal $clog2(CLK_PER_BIT).
REQ-003 clk  input  1  sole clock; all logic on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 tx  output  1  serial line, idle high.
REQ-006 block  input  1  flow-control hold from the downstream link; high SHALL inhibit new frames.
REQ-007 busy  output  1  high SHALL mean no byte can be accepted this cycle.
REQ-008 data  input  8  byte to send; sampled only on acceptance.
REQ-009 new_data  input  1  single-cycle strobe offering data.

Function
REQ-010 States SHALL be IDLE, START_BIT, DATA, PARITY (only with the parity feature), STOP_BIT.
REQ-011 block SHALL be registered once (block_q) before use; acceptance requires state IDLE and block_q=0 and new_data=1.
REQ-012 On acceptance: latch data, clear bit and baud counters, go to START_BIT next cycle.
REQ-013 new_data while busy SHALL be ignored with no side effect; no queueing.
REQ-014 tx SHALL be registered; the first start-bit cycle appears on tx the cycle after acceptance.
REQ-015 START_BIT: tx=0 for CLK_PER_BIT cycles, then DATA.
REQ-016 DATA: 8 bits LSB first, each held CLK_PER_BIT cycles; 3-bit counter wraps 7->0 on exit.
REQ-017 STOP_BIT: tx=1 for CLK_PER_BIT cycles, then IDLE.
REQ-018 busy SHALL be registered: high in every cycle from the cycle after acceptance through the last STOP_BIT cycle, and whenever block_q=1.
REQ-019 busy SHALL drop the cycle after STOP_BIT completes (if block_q=0); a byte offered that cycle SHALL start the next frame with zero idle gap.
REQ-020 block asserted mid-frame SHALL NOT abort or stretch the frame; it only holds busy high afterwards.
REQ-021 Baud counter SHALL count 0..CLK_PER_BIT-1 and reset to 0 on every bit boundary; no cumulative drift.
REQ-022 Frame length SHALL be exactly 10*CLK_PER_BIT cycles (11* with parity).

Reset
REQ-023 On rst: state IDLE, tx=1, busy=0, block_q=0, counters 0, data register 0.
REQ-024 rst mid-frame SHALL abort: tx=1 and busy=0 the cycle after rst is sampled; no partial stop bit sequence.

Configuration
REQ-025 Macro UART_TX_PARITY_EN defined: PARITY state inserted between DATA and STOP_BIT, sending even parity (XOR of the 8 data bits) for CLK_PER_BIT cycles.
REQ-026 Macro undefined: PARITY state and XOR logic absent; 8N1 framing only.

Structure
REQ-027 Shared package uart_pkg SHALL hold the state enum, DATA_BITS=8 and the idle line level constant.
REQ-028 Sub-module uart_baud_ctr (parameter CLK_PER_BIT; inputs clk, rst, clear; output bit_done pulse) SHALL provide bit timing.

Verification (CLK_PER_BIT=4)
REQ-029 Send 0x68 from idle -> tx low 4 cycles, then 0,0,0,1,0,1,1,0 at 4 cycles each, high 4 cycles; busy high 40 cycles.
REQ-030 0x00 then 0xFF offered on the first busy-low cycle -> 80 contiguous frame cycles, no idle between frames.
REQ-031 new_data=1 with 0xFF at cycle 10 of a 0x41 frame -> only 0x41 transmitted; busy low after cycle 40.
REQ-032 block=1 then new_data with 0x55 -> busy=1, tx stays 1, nothing sent; block=0 and re-offer -> frame sent.
REQ-033 rst during DATA bit 3 -> next cycle tx=1, busy=0; fresh 0x12 then sent correctly.
REQ-034 With UART_TX_PARITY_EN, send 0x07 -> parity bit 1 after data, 44-cycle frame; 0x03 -> parity bit 0.
